// File: rtl/karatsuba_seq_mul.sv
// rtl/karatsuba_seq_mul.sv - multi-cycle unsigned multiplier using one level of Karatsuba decomposition
module karatsuba_seq_mul #(
    parameter int N_BITS = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [N_BITS-1:0]     a,
    input  logic [N_BITS-1:0]     b,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [2*N_BITS-1:0]   c,
    output logic                  busy
);

    // Low halves are H bits; high halves are L bits, zero-extended to H.
    localparam int H  = (N_BITS + 1) / 2;
    localparam int L  = N_BITS / 2;
    localparam int PW = 2 * H + 2;
    localparam int CW = 2 * N_BITS;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        MUL_LO  = 3'd1,
        MUL_HI  = 3'd2,
        MUL_MID = 3'd3,
        COMB    = 3'd4,
        DONE    = 3'd5
    } state_t;

    state_t          state_q, state_d;
    logic [H-1:0]    a0_q, a0_d, a1_q, a1_d;
    logic [H-1:0]    b0_q, b0_d, b1_q, b1_d;
    logic [PW-1:0]   z0_q, z0_d, z1_q, z1_d, z2_q, z2_d;
    logic [CW-1:0]   c_q, c_d;
    logic            out_valid_q, out_valid_d;
    logic            in_ready_q, in_ready_d;
    logic            busy_q, busy_d;

    logic [H:0]      sa, sb;
    logic [H:0]      mul_a, mul_b;
    logic [PW-1:0]   prod;

    // Shared multiplier: operands selected by the current product step.
    always_comb begin
        sa = {1'b0, a0_q} + {1'b0, a1_q};
        sb = {1'b0, b0_q} + {1'b0, b1_q};
        mul_a = '0;
        mul_b = '0;
        case (state_q)
            MUL_LO: begin
                mul_a = {1'b0, a0_q};
                mul_b = {1'b0, b0_q};
            end
            MUL_HI: begin
                mul_a = {1'b0, a1_q};
                mul_b = {1'b0, b1_q};
            end
            MUL_MID: begin
                mul_a = sa;
                mul_b = sb;
            end
            default: begin
                mul_a = '0;
                mul_b = '0;
            end
        endcase
        prod = PW'(mul_a) * PW'(mul_b);
    end

    // Next-state and datapath sequencing; outputs are derived from the next state so they are registered.
    always_comb begin
        state_d     = state_q;
        a0_d        = a0_q;
        a1_d        = a1_q;
        b0_d        = b0_q;
        b1_d        = b1_q;
        z0_d        = z0_q;
        z1_d        = z1_q;
        z2_d        = z2_q;
        c_d         = c_q;
        out_valid_d = out_valid_q;
        case (state_q)
            IDLE: begin
                if (in_valid && in_ready_q) begin
                    a0_d    = a[H-1:0];
                    a1_d    = H'(a[H +: L]);
                    b0_d    = b[H-1:0];
                    b1_d    = H'(b[H +: L]);
                    state_d = MUL_LO;
                end
            end
            MUL_LO: begin
                z0_d    = prod;
                state_d = MUL_HI;
            end
            MUL_HI: begin
                z2_d    = prod;
                state_d = MUL_MID;
            end
            MUL_MID: begin
                // (a0+a1)(b0+b1) - a0b0 - a1b1 = a0b1 + a1b0, never negative.
                z1_d    = prod - z0_q - z2_q;
                state_d = COMB;
            end
            COMB: begin
                // The true product fits in CW bits, so modular arithmetic at CW is exact.
                c_d         = (CW'(z2_q) << (2 * H)) + (CW'(z1_q) << H) + CW'(z0_q);
                out_valid_d = 1'b1;
                state_d     = DONE;
            end
            DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d     = IDLE;
                out_valid_d = 1'b0;
            end
        endcase
        in_ready_d = (state_d == IDLE);
        busy_d     = (state_d != IDLE);
    end

    // State and output registers with asynchronous clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            a0_q        <= '0;
            a1_q        <= '0;
            b0_q        <= '0;
            b1_q        <= '0;
            z0_q        <= '0;
            z1_q        <= '0;
            z2_q        <= '0;
            c_q         <= '0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            a0_q        <= a0_d;
            a1_q        <= a1_d;
            b0_q        <= b0_d;
            b1_q        <= b1_d;
            z0_q        <= z0_d;
            z1_q        <= z1_d;
            z2_q        <= z2_d;
            c_q         <= c_d;
            out_valid_q <= out_valid_d;
            in_ready_q  <= in_ready_d;
            busy_q      <= busy_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign c         = c_q;
    assign busy      = busy_q;

endmodule
